maze_reader: RTL
================

// Module: maze_reader
// PURPOSE
//  Reads the packed maze grid written by the maze carver and streams it out one cell at a time,
//  row-major, over a valid/ready handshake. Each beat carries the cell coordinate and its 2-bit type.
//  Sits between the carver output bus and the VGA renderer / player-collision logic.
//  Also counts path cells and pulses finish at the end of each scan.
// PARAMETERS
//  GRID_W     64  cells per row; row = 128 bits = GRID_W*2
//  GRID_H     64  rows in the grid
//  CELL_BITS  2   bits per cell; encoding 00 out, 01 frontier, 10 wall, 11 path
// PORTS
//  clk          in   1     system clock, rising edge
//  reset        in   1     asynchronous, active-high; clears all state
//  start        in   1     begin a scan; sampled only in IDLE
//  x_dimension  in   3     active width  = 8*(x_dimension+1) cells, sampled at start
//  y_dimension  in   3     active height = 8*(y_dimension+1) rows, sampled at start
//  maze_data    in   8192  packed grid; cell (x,y) = maze_data[x*2 + y*128 +: 2]
//  cell_valid   out  1     current beat is valid
//  cell_ready   in   1     downstream accepts the beat
//  cell_x       out  6     column of the current beat
//  cell_y       out  6     row of the current beat
//  cell_type    out  2     type of cell (cell_x,cell_y)
//  cell_last    out  1     beat is the final cell of the active region
//  path_count   out  13    number of accepted beats with cell_type==2'b11 (max 4096)
//  busy         out  1     high in SCAN
//  finish       out  1     one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; latched dims=0.
//  FSM IDLE -> SCAN on start. SCAN -> DONE when the last beat is accepted. DONE -> IDLE after 1 cycle.
//  On start in IDLE:
//   - xmax=8*x_dimension+7, ymax=8*y_dimension+7
//   - path_count cleared
//   - on the next cycle: cell_valid=1, cell_x=0, cell_y=0, cell_type loaded.
//  Beat transfers when cell_valid & cell_ready. Next beat is presented the following cycle, so
//   full throughput is 1 cell/clk.
//  Advance: if x==xmax then x=0, y=y+1, else x=x+1. Cells beyond xmax/ymax are never emitted.
//  cell_x, cell_y, cell_type and cell_last are registered and held stable while valid & !ready.
//   cell_valid never drops without a transfer.
//  cell_last = (cell_x==xmax) & (cell_y==ymax).
//  path_count increments by 1 on each transfer with cell_type==2'b11. It holds after the scan until
//   the next start.
//  Last transfer: cell_valid=0 next cycle, FSM=DONE, finish=1 for exactly that cycle, then IDLE.
//  start while in SCAN or DONE: ignored; it does not restart or queue.
//  start and reset asserted together: reset wins.
//  Reset mid-scan: abort immediately; cell_valid and finish are not asserted afterwards.
//  Dimension inputs changing mid-scan: no effect (latched at start).
// CONFIGURATION
//  MAZE_READER_SNAPSHOT_EN defined:
//   - maze_data is copied into an internal 8192-bit register on the start cycle.
//   - Every beat reads the snapshot, so carver writes during the scan are not visible.
//  Not defined:
//   - No snapshot register. cell_type samples live maze_data at the cycle the coordinate is loaded.
//   - A cell changed after its load and before its transfer is not re-read.
// TESTING
//  1. reset; start with x_dim=0, y_dim=0, ready=1, all-zero grid
//     -> 64 beats (0,0)..(7,7) on consecutive cycles; cell_last only on (7,7);
//        finish on the cycle after; path_count=0.
//  2. grid with cells (0,0),(5,3),(7,7) = 11, rest 00; 8x8 scan
//     -> cell_type=11 on exactly those 3 beats; path_count=3 at finish.
//  3. cell_ready low for 4 cycles on the beat at (2,1)
//     -> cell_x=2, cell_y=1, cell_type and cell_valid held constant; next beat is (3,1).
//  4. x_dim=7, y_dim=7, ready=1
//     -> 4096 beats; row wrap from (63,0) to (0,1); last beat (63,63); finish exactly once.
//  5. assert reset during beat (4,2)
//     -> all outputs 0 immediately; no finish; a new start then begins at (0,0).
//  6. with the macro, change maze cell (6,6) from 00 to 11 mid-scan
//     -> the (6,6) beat reports 00;
//     without the macro, a change made before the (6,6) coordinate is loaded -> beat reports 11.

Source files
------------

// File: rtl/maze_reader.sv
// maze_reader: streams the packed maze grid out one cell per beat, row-major,
// over a valid/ready handshake. It counts path cells and pulses finish once
// at the end of each scan.
// Optional build macro: MAZE_READER_SNAPSHOT_EN. When it is defined, the grid
// is frozen into an internal register on the start cycle. Without it, each
// cell reads live maze_data at the moment its coordinate is loaded.
module maze_reader #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 64,
    parameter int CELL_BITS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        x_dimension,
    input  logic [2:0]                        y_dimension,
    input  logic [GRID_W*GRID_H*CELL_BITS-1:0] maze_data,
    output logic                              cell_valid,
    input  logic                              cell_ready,
    output logic [$clog2(GRID_W)-1:0]         cell_x,
    output logic [$clog2(GRID_H)-1:0]         cell_y,
    output logic [CELL_BITS-1:0]              cell_type,
    output logic                              cell_last,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] path_count,
    output logic                              busy,
    output logic                              finish
);

    localparam int X_W       = $clog2(GRID_W);
    localparam int Y_W       = $clog2(GRID_H);
    localparam int PC_W      = $clog2(GRID_W*GRID_H+1);
    localparam int GRID_BITS = GRID_W*GRID_H*CELL_BITS;
    localparam logic [CELL_BITS-1:0] PATH_CELL = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [X_W-1:0]         xmax_q;
    logic [Y_W-1:0]         ymax_q;
    logic [X_W-1:0]         next_x;
    logic [Y_W-1:0]         next_y;
    logic                   next_last;
    logic                   xfer;
    logic [GRID_BITS-1:0]   grid_src;

    // Extract one cell from the packed grid: cell (x,y) sits at bit (y*GRID_W + x)*CELL_BITS.
    function automatic logic [CELL_BITS-1:0] cell_at(
        input logic [GRID_BITS-1:0] grid,
        input logic [X_W-1:0]       x,
        input logic [Y_W-1:0]       y
    );
        int base;
        base = (int'(y) * GRID_W + int'(x)) * CELL_BITS;
        return grid[base +: CELL_BITS];
    endfunction

    assign xfer = cell_valid & cell_ready;

`ifdef MAZE_READER_SNAPSHOT_EN
    logic [GRID_BITS-1:0] snap_q;

    // Freeze the whole grid on the start cycle so carver writes during the scan are invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            snap_q <= maze_data;
        end
    end

    assign grid_src = snap_q;
`else
    assign grid_src = maze_data;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; busy and finish are decoded straight from the state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (xfer && cell_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Row-major advance: wrap the column at xmax and step to the next row.
    always_comb begin
        next_x = cell_x + X_W'(1);
        next_y = cell_y;
        if (cell_x == xmax_q) begin
            next_x = '0;
            next_y = cell_y + Y_W'(1);
        end
        next_last = (next_x == xmax_q) && (next_y == ymax_q);
    end

    // Beat registers and path counter: load on start, advance on each transfer, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xmax_q     <= '0;
            ymax_q     <= '0;
            cell_valid <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_type  <= '0;
            cell_last  <= 1'b0;
            path_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        xmax_q     <= X_W'({x_dimension, 3'b111});
                        ymax_q     <= Y_W'({y_dimension, 3'b111});
                        path_count <= '0;
                        cell_valid <= 1'b1;
                        cell_x     <= '0;
                        cell_y     <= '0;
                        // The snapshot is being captured this same edge, so read the live bus here.
                        cell_type  <= cell_at(maze_data, '0, '0);
                        // Smallest region is 8x8, so (0,0) is never the final cell.
                        cell_last  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (xfer) begin
                        if (cell_type == PATH_CELL) begin
                            path_count <= path_count + PC_W'(1);
                        end
                        if (cell_last) begin
                            cell_valid <= 1'b0;
                        end else begin
                            cell_x    <= next_x;
                            cell_y    <= next_y;
                            cell_type <= cell_at(grid_src, next_x, next_y);
                            cell_last <= next_last;
                        end
                    end
                end
                default: begin
                    cell_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
